// File: rtl/botswdrive_ctrl_if.sv
// botswdrive_ctrl_if: enable, request, gate-sense and drive/status signals of the low-side driver
interface botswdrive_ctrl_if;
  logic en;
  logic bot_req;
  logic top_gate_sns;
  logic bot_gate_sns;
  logic fault_clr;
  logic bot_drv;
  logic bot_on;
  logic fault;
  modport master (
    output en, bot_req, top_gate_sns, bot_gate_sns, fault_clr,
    input  bot_drv, bot_on, fault
  );
  modport slave (
    input  en, bot_req, top_gate_sns, bot_gate_sns, fault_clr,
    output bot_drv, bot_on, fault
  );
endinterface

// File: rtl/botswdrive_ctrl.sv
// botswdrive_ctrl: low-side gate sequencer with deadtime, min-on time and gate-sense fault supervision
module botswdrive_ctrl #(
  parameter int DEADTIME_CYC = 4,
  parameter int MINON_CYC    = 3,
  parameter int GATE_TO_CYC  = 15
) (
  input logic clk,
  input logic rst,
  botswdrive_ctrl_if.slave bus
);
  localparam logic [3:0] DT_LAST = 4'(DEADTIME_CYC - 1);
  localparam logic [3:0] TO_LAST = 4'(GATE_TO_CYC - 1);
  localparam logic [3:0] MINON   = 4'(MINON_CYC);
  typedef enum logic [2:0] {OFF, DEAD, CHARGE, ON, DISCHG, FAULT} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  always_comb begin
    state_n = state;
    case (state)
      OFF:     state_n = (bus.en && bus.bot_req && !bus.top_gate_sns) ? DEAD : OFF;
      DEAD:    state_n = (bus.top_gate_sns || !bus.bot_req || !bus.en) ? OFF :
                         (cnt == DT_LAST) ? CHARGE : DEAD;
      CHARGE:  state_n = (cnt == TO_LAST) ? FAULT : bus.bot_gate_sns ? ON : CHARGE;
      ON:      state_n = bus.top_gate_sns ? FAULT : !bus.en ? DISCHG :
                         !bus.bot_gate_sns ? FAULT : (!bus.bot_req && cnt >= MINON) ? DISCHG : ON;
      DISCHG:  state_n = (cnt == TO_LAST) ? FAULT : !bus.bot_gate_sns ? OFF : DISCHG;
      FAULT:   state_n = (bus.fault_clr && !bus.bot_gate_sns) ? OFF : FAULT;
      default: state_n = OFF;
    endcase
    // every state entry restarts the count; ON stops counting once min-on is met
    cnt_n = (state_n != state || state == OFF || state == FAULT) ? 4'd0 :
            (cnt == 4'd15 || (state == ON && cnt >= MINON)) ? cnt : cnt + 4'd1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= OFF;
      cnt         <= 4'd0;
      bus.bot_drv <= 1'b0;
      bus.bot_on  <= 1'b0;
      bus.fault   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bus.bot_drv <= state_n inside {CHARGE, ON};
      bus.bot_on  <= state_n == ON;
      bus.fault   <= state_n == FAULT;
    end
endmodule
